godai_mem_responder: RTL and testbench

- Memory-side responder for the core's req/gnt/rvalid instruction and data memory interfaces.
- Accepts requests from the initiator and grants them, then returns in-order responses after a fixed latency from a word-addressed on-chip RAM.
- One instance backs the instruction port and one backs the data port in the Godai simulation and FPGA top level.

---
 rtl/godai_mem_pkg.sv | 33 +++
 rtl/godai_mem_ram.sv | 34 +++
 rtl/godai_mem_responder.sv | 144 ++++++++++++++
 tb/tb_godai_mem_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/godai_mem_pkg.sv
// Shared types and helpers for the Godai memory responder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package godai_mem_pkg;

    // One pipeline slot: response valid, access error and read data.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    // Random-stall LFSR: Fibonacci, taps 16,14,13,11 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Replace the byte lanes selected by be with the matching lanes of wdata.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_w;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                merged[8*n +: 8] = wdata[8*n +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/godai_mem_ram.sv
// Single-port byte-enable synchronous RAM, DEPTH_WORDS x 32, read-first.
// Latency: read data appears one clock after i_en.
// Backpressure: none; one access per enabled cycle.
module godai_mem_ram
    import godai_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Read-first port: the old word is captured before the lane merge lands.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= byte_merge(r_mem[i_addr], i_wdata, i_be);
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/godai_mem_responder.sv
// req/gnt/rvalid memory responder backed by on-chip RAM; optional GODAI_MEM_RANDOM_STALL_EN adds LFSR grant stalls.
// Latency: rvalid_o LATENCY cycles after the granting edge, responses in order.
// Backpressure: gnt_o withheld once MAX_OUTSTANDING responses are pending (unless one retires this cycle); responses cannot stall.
module godai_mem_responder
    import godai_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    DEPTH_WORDS     = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    LATENCY         = 1,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0]         r_count;
    logic                  r_s0_valid;
    logic                  r_s0_err;
    logic                  r_s0_rd;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_stall;
    logic [31:0]           w_ram_rdata;
    resp_t                 w_s0;
    resp_t                 w_out;

    // Range check: a wrapped subtraction (addr below base) yields a huge index.
    assign w_off      = addr_i - BASE_ADDR;
    assign w_word     = w_off >> 2;
    assign w_in_range = (addr_i >= BASE_ADDR) && (w_word < ADDR_WIDTH'(DEPTH_WORDS));

`ifdef GODAI_MEM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running stall generator, advances every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // A retiring response frees its slot in the same cycle, so a full counter can still grant.
    assign gnt_o    = req_i && !w_stall
                      && ((r_count < CW'(MAX_OUTSTANDING)) || rvalid_o);
    assign w_accept = req_i && gnt_o;

    godai_mem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk    (clk),
        .i_en   (w_accept && w_in_range),
        .i_we   (we_i),
        .i_be   (be_i),
        .i_addr (w_word[AW-1:0]),
        .i_wdata(wdata_i),
        .o_rdata(w_ram_rdata)
    );

    // Stage 0 flags; its read data lives in the RAM output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_err   <= 1'b0;
            r_s0_rd    <= 1'b0;
        end else begin
            r_s0_valid <= w_accept;
            r_s0_err   <= w_accept && !w_in_range;
            r_s0_rd    <= w_accept && w_in_range && !we_i;
        end
    end

    // Writes and errors return zero data; only in-range reads expose the RAM word.
    always_comb begin
        w_s0       = '0;
        w_s0.valid = r_s0_valid;
        w_s0.err   = r_s0_err;
        w_s0.rdata = r_s0_rd ? w_ram_rdata : 32'h0;
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            resp_t r_pipe [1:LATENCY-1];

            // Remaining delay stages; reset drops every in-flight response.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 1; i < LATENCY; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[1] <= w_s0;
                    for (int i = 2; i < LATENCY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_out = r_pipe[LATENCY-1];
        end else begin : g_nopipe
            assign w_out = w_s0;
        end
    endgenerate

    assign rvalid_o = w_out.valid;
    assign err_o    = w_out.err;
    assign rdata_o  = w_out.rdata;

    // Outstanding count: accept adds one, a retiring response removes one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_accept, rvalid_o})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_godai_mem_responder.sv
`timescale 1ns/1ps
module tb_godai_mem_responder;

    localparam int          DEPTH = 4096;
    localparam int          MAXO  = 2;
    localparam int          LAT0  = 1;
    localparam int          LAT1  = 3;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        req    [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic        err    [2];
    logic [31:0] rdata  [2];

    always #5 clk = ~clk;

    godai_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE0), .LATENCY(LAT0), .MAX_OUTSTANDING(MAXO)
    ) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .rdata_o(rdata[0]), .err_o(err[0])
    );

    godai_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE1), .LATENCY(LAT1), .MAX_OUTSTANDING(MAXO)
    ) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .rdata_o(rdata[1]), .err_o(err[1])
    );

    // Expected response: the cycle it must appear in and its contents.
    typedef struct packed {
        int          due;
        bit          err;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mmem [2][DEPTH];
    logic [3:0]  kb   [2][DEPTH];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          rv_cnt [2];
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    int          stall_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Per-cycle model: outstanding responses are a queue of due cycles.
    task automatic cmp(input int k);
        int          outs;
        int          lat;
        bit          exp_rv;
        bit          base_ok;
        bit          inr;
        exp_t        e;
        exp_t        n;
        longint      a;
        longint      b;
        int          idx;
        lat = (k == 0) ? LAT0 : LAT1;
        b   = (k == 0) ? longint'(BASE0) : longint'(BASE1);
        if (rst[k]) begin
            if (k == 0) q0.delete(); else q1.delete();
            check("rst_rvalid", 32'(rvalid[k]), 0);
            check("rst_gnt", 32'(gnt[k]), 0);
            check("rst_err", 32'(err[k]), 0);
            check("rst_rdata", rdata[k], 0);
            return;
        end
        outs   = qsize(k);
        exp_rv = 1'b0;
        e      = '0;
        if (outs > 0) begin
            if (k == 0) e = q0[0]; else e = q1[0];
            exp_rv = (e.due == cyc);
        end
        if (rvalid[k] === 1'b1) begin
            rv_cnt[k]++;
            last_rdata[k] = rdata[k];
            last_err[k]   = err[k];
        end
        check("rvalid", 32'(rvalid[k]), 32'(exp_rv));
        if (exp_rv) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            check("err", 32'(err[k]), 32'(e.err));
            if (e.chk) check("rdata", rdata[k], e.data);
        end
        base_ok = req[k] && ((outs < MAXO) || exp_rv);
        if (req[k] && base_ok && !gnt[k]) stall_seen++;
`ifdef GODAI_MEM_RANDOM_STALL_EN
        check("gnt_rule", 32'(gnt[k] && !base_ok), 0);
`else
        check("gnt", 32'(gnt[k]), 32'(base_ok));
`endif
        if (req[k] && gnt[k]) begin
            a     = longint'(addr[k]);
            inr   = (a >= b) && (a < b + 4 * DEPTH);
            n     = '0;
            n.due = cyc + lat;
            n.err = !inr;
            n.chk = 1'b1;
            if (inr) begin
                idx = int'((a - b) / 4);
                if (we[k]) begin
                    for (int j = 0; j < 4; j++) begin
                        if (be[k][j]) mmem[k][idx][8*j +: 8] = wdata[k][8*j +: 8];
                    end
                    kb[k][idx] = kb[k][idx] | be[k];
                end else begin
                    n.data = mmem[k][idx];
                    n.chk  = (kb[k][idx] == 4'hF);
                end
            end
            if (k == 0) q0.push_back(n); else q1.push_back(n);
        end
    endtask

    always @(negedge clk) begin
        cmp(0);
        cmp(1);
        cyc++;
    end

    // Present one request and hold it until granted; returns just after the accepting edge.
    task automatic do_req(input int k, input bit w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok       = 1'b0;
        req[k]   = 1'b1;
        we[k]    = w;
        be[k]    = b;
        addr[k]  = a;
        wdata[k] = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (gnt[k]) begin
                ok = 1'b1;
                break;
            end
        end
        check("grant_wait", 32'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        req[k]   = 1'b0;
        we[k]    = 1'b0;
        be[k]    = 4'h0;
        addr[k]  = 32'h0;
        wdata[k] = 32'h0;
    endtask

    task automatic drain(input int k);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (qsize(k) == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("drain", 32'(ok), 1);
    endtask

    task automatic prewrite(input int k, input logic [31:0] base);
        for (int w = 0; w < 16; w++) do_req(k, 1'b1, 4'hF, base + 32'(4 * w), $urandom);
        idle(k);
        drain(k);
    endtask

    task automatic rand_phase(input int k, input logic [31:0] base, input int nops);
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < nops; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else if (sel == 8) a = base + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
            else               a = (i % 2 == 0) ? base - 32'd4 : 32'hFFFF_FFF0;
            do_req(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                idle(k);
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        idle(k);
        drain(k);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [5:0] gpat;
        bit         g;
        int         nrv;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0;
            rv_cnt[k] = 0;
            last_rdata[k] = '0;
            last_err[k] = 1'b0;
            idle(k);
            for (int w = 0; w < DEPTH; w++) begin
                mmem[k][w] = '0;
                kb[k][w]   = 4'h0;
            end
        end
        #1;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // LATENCY=1: write then read back, response one cycle after the grant.
        do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        check("lat1_rvalid", 32'(rvalid[0]), 1);
        idle(0);
        drain(0);
        check("wr_err", 32'(last_err[0]), 0);
        check("wr_rdata", last_rdata[0], 32'h0);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0);
        idle(0);
        drain(0);
        check("rd_data", last_rdata[0], 32'hDEADBEEF);

        // Partial write immediately followed by a read of the same word.
        do_req(0, 1'b1, 4'b0101, 32'h10, 32'h11223344);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0);
        idle(0);
        drain(0);
        check("be_merge", last_rdata[0], 32'hDE22BE44);

        // Out-of-range read and write leave word 0 intact.
        do_req(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D);
        do_req(0, 1'b1, 4'hF, 32'h4000, 32'h55555555);
        do_req(0, 1'b0, 4'hF, 32'h4000, 32'h0);
        idle(0);
        drain(0);
        check("oor_err", 32'(last_err[0]), 1);
        check("oor_rdata", last_rdata[0], 32'h0);
        do_req(0, 1'b0, 4'hF, 32'h0, 32'h0);
        idle(0);
        drain(0);
        check("after_oor", last_rdata[0], 32'hCAFEF00D);
        check("after_oor_err", 32'(last_err[0]), 0);

        // Non-zero base: an address just below it wraps and must be rejected.
        prewrite(1, BASE1);
        do_req(1, 1'b0, 4'hF, BASE1 - 32'd4, 32'h0);
        idle(1);
        drain(1);
        check("below_base_err", 32'(last_err[1]), 1);
        do_req(1, 1'b0, 4'hF, BASE1 + 32'(4 * DEPTH) - 32'd4, 32'h0);
        idle(1);
        drain(1);
        check("top_word_err", 32'(last_err[1]), 0);

`ifndef GODAI_MEM_RANDOM_STALL_EN
        // LATENCY=3, two outstanding, req held: grants 1,1,0 repeating.
        gpat = '0;
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = BASE1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            g = gnt[1];
            if (i < 6) gpat = {gpat[4:0], g};
            @(posedge clk);
            #1;
            if (g) addr[1] = BASE1 + ((addr[1] - BASE1 + 32'd4) & 32'h3C);
        end
        idle(1);
        drain(1);
        check("gnt_pattern", 32'(gpat), 32'(6'b110110));
`endif

        // Reset with two reads in flight: neither may ever respond.
        do_req(1, 1'b0, 4'hF, BASE1 + 32'h8, 32'h0);
        do_req(1, 1'b0, 4'hF, BASE1 + 32'hC, 32'h0);
        idle(1);
        nrv = rv_cnt[1];
        rst[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_rvalid", 32'(rv_cnt[1] - nrv), 0);
        do_req(1, 1'b0, 4'hF, BASE1, 32'h0);
        do_req(1, 1'b0, 4'hF, BASE1 + 32'h4, 32'h0);
        idle(1);
        drain(1);

        // Randomized traffic on both instances.
        prewrite(0, BASE0);
        rand_phase(0, BASE0, 300);
        rand_phase(1, BASE1, 300);

        // Long run of back-to-back reads with req held.
        for (int i = 0; i < 1000; i++) do_req(0, 1'b0, 4'hF, BASE0 + 32'(4 * $urandom_range(0, 15)), 32'h0);
        idle(0);
        drain(0);
`ifdef GODAI_MEM_RANDOM_STALL_EN
        check("stall_seen", 32'(stall_seen > 0), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
